sseg_scan_ctrl: RTL and testbench
=================================

# sseg_scan_ctrl

Parametrised multiplexed seven-segment scan controller: drives NUM_DIGITS common-anode digits from a packed hex vector, with a built-in refresh prescaler, per-digit decimal points, anti-ghosting dead time, and tear-free frame-synchronous updates. It replaces the fixed four-digit controller (the separate clock divider, digit mux, cathode decoder and anode decoder) in board top levels, and sits directly between datapath result registers and the board display pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (2..8)
- CLK_DIV, 100000, clk cycles per digit slot (≥ 2)
- DEAD, 2, cycles at the start of each slot with all anodes off (0 ≤ DEAD < CLK_DIV)
- ACTIVE_LOW, 1, 1 = anodes/cathodes/dp driven low-true (Basys3); 0 = high-true
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- digits  in  4*NUM_DIGITS  hex nibbles; digit 0 in [3:0] (rightmost)
- dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
- load  in  1  capture strobe for digits/dp
- seg_an  out  NUM_DIGITS  anode enables
- seg_cat  out  7  cathodes, [0]=a … [6]=g
- seg_dp  out  1  decimal point cathode
- frame_done  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0

## Operation
- Prescaler counts 0..CLK_DIV-1; at terminal count it returns to 0 and the digit index advances; the index wraps NUM_DIGITS-1 → 0.
- Three register sets: pending (written on load), pend_valid flag, display (the value actually scanned).
- load=1: pending ← {digits, dp}; pend_valid ← 1.
- Frame boundary (terminal count with index = NUM_DIGITS-1): if load is asserted in the same cycle, display ← inputs directly; else if pend_valid, display ← pending. pend_valid clears in either case. Mid-frame loads never alter the digits being shown.
- Slot output: for prescaler < DEAD, all anodes off and cathodes off; otherwise enable only the anode of the current index and drive its decoded nibble and dp.
- Decoder: full hex 0–F. Logical segment patterns {g..a}: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001. ACTIVE_LOW inverts seg_an, seg_cat and seg_dp.
- Reset: prescaler=0, index=0, pending=display=0, pend_valid=0. All outputs are off (ACTIVE_LOW=1: seg_an all 1, seg_cat=7'h7F, seg_dp=1), frame_done=0.
- Reset asserted mid-frame aborts the scan immediately; the first slot after reset is digit 0 with its dead time.

## Timing
- All outputs are registered: the pin state reflects the prescaler/index of the previous cycle (1-cycle latency).
- Digit slot = CLK_DIV cycles, of which CLK_DIV-DEAD are lit; frame = NUM_DIGITS*CLK_DIV cycles.
- frame_done is asserted in the cycle after the wrap edge, coincident with the first dead cycle of digit 0.
- A load becomes visible at most one frame + 1 cycle later, and never before the next frame boundary.

## Configuration
- SSEG_LZB_EN defined: leading-zero blanking. Digits from NUM_DIGITS-1 downward that are 0 and precede the first nonzero digit have their cathodes blanked. Digit 0 is never blanked. The blanking mask is computed from the display register. The dp of a blanked digit still lights if set.
- Undefined: every digit shows its nibble, including leading zeros.

## Structure
- Shared package sseg_pkg holds the 16-entry segment pattern constant (logical, active-high) and a localparam helper for the index width ($clog2(NUM_DIGITS), minimum 1).
- One sub-module: sseg_hex_decode (combinational nibble → 7-bit pattern), instantiated once on the selected digit. The prescaler, index, shadow registers and output registers stay in sseg_scan_ctrl.

## Test plan
Bench parameters: NUM_DIGITS=4, CLK_DIV=4, DEAD=1, ACTIVE_LOW=1.
- Reset, then idle 20 cycles → seg_an=4'hF, seg_cat=7'h7F, seg_dp=1, frame_done=0 throughout reset; after reset, digit 0 has 1 dead cycle then seg_an=4'b1110.
- load digits=16'h12AF, dp=4'b0100, then run 2 frames → second frame shows per slot seg_an 1110/1101/1011/0111 with seg_cat 0001110 (F), 0001000 (A), 0100100 (2), 1111001 (1), seg_dp low only on digit 2; frame_done pulses every 16 cycles.
- load 16'h1111 mid-frame at index 1, then 16'h2222 at index 2 → no change until the wrap; the next frame shows 2222.
- load coincident with the terminal count of digit 3 → the new value is shown in the immediately following digit-0 slot; pend_valid is clear afterwards.
- SSEG_LZB_EN defined, load 16'h0040 → digits 3 and 2 blanked (seg_cat=7'h7F during their slots), digit 1 shows 4, digit 0 shows 0; load 16'h0000 → only digit 0 is lit.
- Assert rst for 1 cycle during digit 2 → the next cycle has all outputs off, and the scan restarts at digit 0 with display cleared to 0000.

Source files
------------

// File: rtl/sseg_pkg.sv
// ============================================================================
// Module      : sseg_pkg
// Description : Shared constants and helpers for the seven-segment scan
//               controller: the logical hex segment table and the
//               digit-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sseg_pkg;

    typedef logic [6:0] seg_t;

    // Logical (active-high) patterns, bit order {g,f,e,d,c,b,a}; entry 0 in the LSBs.
    localparam logic [16*7-1:0] c_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        return c_SEG_TABLE[7*nib +: 7];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sseg_hex_decode.sv
// ============================================================================
// Module      : sseg_hex_decode
// Description : Combinational hex nibble to logical seven-segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = hex_to_seg(i_nibble);
    end

endmodule

`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
// ============================================================================
// Module      : sseg_scan_ctrl
// Description : Multiplexed common-anode seven-segment scan controller with
//               refresh prescaler, dead time and frame-synchronous updates.
//               Optional leading-zero blanking: define SSEG_LZB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 100000,
    parameter int DEAD       = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   seg_an,
    output logic [6:0]              seg_cat,
    output logic                    seg_dp,
    output logic                    frame_done
);

    localparam int              c_PW         = $clog2(CLK_DIV);
    localparam int              c_IW         = idx_width(NUM_DIGITS);
    localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(CLK_DIV - 1);
    localparam logic [c_IW-1:0] c_IDX_LAST   = c_IW'(NUM_DIGITS - 1);
    localparam logic            c_INV        = (ACTIVE_LOW != 0);

    logic [c_PW-1:0]         r_presc_q, w_presc_d;
    logic [c_IW-1:0]         r_idx_q, w_idx_d;
    logic [4*NUM_DIGITS-1:0] r_pend_dig_q, w_pend_dig_d;
    logic [NUM_DIGITS-1:0]   r_pend_dp_q, w_pend_dp_d;
    logic                    r_pend_valid_q, w_pend_valid_d;
    logic [4*NUM_DIGITS-1:0] r_disp_dig_q, w_disp_dig_d;
    logic [NUM_DIGITS-1:0]   r_disp_dp_q, w_disp_dp_d;
    logic [NUM_DIGITS-1:0]   r_an_q, w_an_d;
    logic [6:0]              r_cat_q, w_cat_d;
    logic                    r_dp_q, w_dp_d;
    logic                    r_frame_done_q;

    logic                    w_tc;
    logic                    w_wrap;
    logic                    w_dead;
    logic [3:0]              w_nib;
    logic                    w_cur_dp;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic                    w_cur_blank;
    logic [6:0]              w_seg;

    // ------------------------------------------------------------------
    // Prescaler, digit index and shadow registers
    // ------------------------------------------------------------------
    always_comb begin
        w_tc   = (r_presc_q == c_PRESC_LAST);
        w_wrap = w_tc && (r_idx_q == c_IDX_LAST);

        w_presc_d = w_tc ? '0 : r_presc_q + c_PW'(1);
        w_idx_d   = r_idx_q;
        if (w_tc) begin
            w_idx_d = (r_idx_q == c_IDX_LAST) ? '0 : r_idx_q + c_IW'(1);
        end

        w_pend_dig_d   = r_pend_dig_q;
        w_pend_dp_d    = r_pend_dp_q;
        w_pend_valid_d = r_pend_valid_q;
        w_disp_dig_d   = r_disp_dig_q;
        w_disp_dp_d    = r_disp_dp_q;

        if (load) begin
            w_pend_dig_d   = digits;
            w_pend_dp_d    = dp;
            w_pend_valid_d = 1'b1;
        end

        // A load landing on the wrap edge bypasses the pending set.
        if (w_wrap) begin
            if (load) begin
                w_disp_dig_d = digits;
                w_disp_dp_d  = dp;
            end else if (r_pend_valid_q) begin
                w_disp_dig_d = r_pend_dig_q;
                w_disp_dp_d  = r_pend_dp_q;
            end
            w_pend_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Current-slot selection
    // ------------------------------------------------------------------
    generate
        if (DEAD == 0) begin : g_no_dead
            assign w_dead = 1'b0;
        end else begin : g_dead
            assign w_dead = (r_presc_q < c_PW'(DEAD));
        end
    endgenerate

    always_comb begin
        w_nib    = 4'h0;
        w_cur_dp = 1'b0;
        w_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx_q == c_IW'(i)) begin
                w_nib       = r_disp_dig_q[4*i +: 4];
                w_cur_dp    = r_disp_dp_q[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

`ifdef SSEG_LZB_EN
    logic w_seen_nz;

    always_comb begin
        w_blank   = '0;
        w_seen_nz = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_seen_nz  = w_seen_nz | (r_disp_dig_q[4*i +: 4] != 4'h0);
            w_blank[i] = ~w_seen_nz;
        end
    end
`else
    assign w_blank = '0;
`endif

    assign w_cur_blank = |(w_blank & w_onehot);

    sseg_hex_decode u_hex_decode (
        .i_nibble (w_nib),
        .o_seg    (w_seg)
    );

    // ------------------------------------------------------------------
    // Output stage (pin polarity applied before the output flops)
    // ------------------------------------------------------------------
    always_comb begin
        w_an_d  = (w_dead ? '0 : w_onehot) ^ {NUM_DIGITS{c_INV}};
        w_cat_d = ((w_dead || w_cur_blank) ? 7'h00 : w_seg) ^ {7{c_INV}};
        w_dp_d  = (~w_dead & w_cur_dp) ^ c_INV;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc_q      <= '0;
            r_idx_q        <= '0;
            r_pend_dig_q   <= '0;
            r_pend_dp_q    <= '0;
            r_pend_valid_q <= 1'b0;
            r_disp_dig_q   <= '0;
            r_disp_dp_q    <= '0;
            r_an_q         <= {NUM_DIGITS{c_INV}};
            r_cat_q        <= {7{c_INV}};
            r_dp_q         <= c_INV;
            r_frame_done_q <= 1'b0;
        end else begin
            r_presc_q      <= w_presc_d;
            r_idx_q        <= w_idx_d;
            r_pend_dig_q   <= w_pend_dig_d;
            r_pend_dp_q    <= w_pend_dp_d;
            r_pend_valid_q <= w_pend_valid_d;
            r_disp_dig_q   <= w_disp_dig_d;
            r_disp_dp_q    <= w_disp_dp_d;
            r_an_q         <= w_an_d;
            r_cat_q        <= w_cat_d;
            r_dp_q         <= w_dp_d;
            r_frame_done_q <= w_wrap;
        end
    end

    assign seg_an     = r_an_q;
    assign seg_cat    = r_cat_q;
    assign seg_dp     = r_dp_q;
    assign frame_done = r_frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
// ============================================================================
// Module      : tb_sseg_scan_ctrl
// Description : Self-checking bench for sseg_scan_ctrl against a time-based
//               reference model (slot = t / CLK_DIV, frame = t / 16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sseg_scan_ctrl;

    localparam int N     = 4;
    localparam int CDIV  = 4;
    localparam int DT    = 1;
    localparam int FRAME = N * CDIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = '0;
    logic [3:0]  dp = '0;
    logic        load = 1'b0;
    logic [3:0]  seg_an;
    logic [6:0]  seg_cat;
    logic        seg_dp;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    // Logical {g..a} patterns for hex 0..F.
    logic [6:0] seg_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // Reference model state: cycles since reset, display, pending.
    int          m_t = 0;
    logic [15:0] m_dd = '0, m_pd = '0;
    logic [3:0]  m_ddp = '0, m_pdp = '0;
    logic        m_pv = 1'b0;
    logic [3:0]  e_an;
    logic [6:0]  e_cat;
    logic        e_dp, e_fd;

    sseg_scan_ctrl #(
        .NUM_DIGITS (N),
        .CLK_DIV    (CDIV),
        .DEAD       (DT),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp         (dp),
        .load       (load),
        .seg_an     (seg_an),
        .seg_cat    (seg_cat),
        .seg_dp     (seg_dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, predict the pins after the edge, advance.
    task automatic step(input logic r, input logic ld, input logic [15:0] dg, input logic [3:0] d);
        int   off, slot;
        logic lit, blank;
        logic [3:0] nib;
        rst = r; load = ld; digits = dg; dp = d;
        if (r) begin
            e_an = 4'hF; e_cat = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
            m_t = 0; m_dd = '0; m_ddp = '0; m_pd = '0; m_pdp = '0; m_pv = 1'b0;
        end else begin
            off   = m_t % CDIV;
            slot  = (m_t / CDIV) % N;
            lit   = (off >= DT);
            nib   = m_dd[slot*4 +: 4];
            blank = 1'b0;
`ifdef SSEG_LZB_EN
            if (slot > 0 && (m_dd >> (slot*4)) == 16'h0) blank = 1'b1;
`endif
            e_an  = lit ? ~(4'b0001 << slot) : 4'hF;
            e_cat = (lit && !blank) ? ~seg_tab[nib] : 7'h7F;
            e_dp  = lit ? ~m_ddp[slot] : 1'b1;
            e_fd  = (m_t % FRAME) == FRAME - 1;
            if (ld) begin
                m_pd = dg; m_pdp = d; m_pv = 1'b1;
            end
            if ((m_t % FRAME) == FRAME - 1) begin
                if (ld) begin
                    m_dd = dg; m_ddp = d;
                end else if (m_pv) begin
                    m_dd = m_pd; m_ddp = m_pdp;
                end
                m_pv = 1'b0;
            end
            m_t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 16'h0, 4'h0);
            total++;
            if ({seg_an, seg_cat, seg_dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL reset_off got an=%b cat=%b dp=%b fd=%b want an=1111 cat=1111111 dp=1 fd=0",
                         seg_an, seg_cat, seg_dp, frame_done);
            end
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0);
            total++;
            if ({seg_an, seg_cat, seg_dp, frame_done} !== {e_an, e_cat, e_dp, e_fd}) begin
                bad++;
                $display("FAIL idle t=%0d got an=%b cat=%b dp=%b fd=%b want an=%b cat=%b dp=%b fd=%b",
                         m_t, seg_an, seg_cat, seg_dp, frame_done, e_an, e_cat, e_dp, e_fd);
            end
            if (i == 1) begin
                total++;
                if (seg_an !== 4'b1110) begin
                    bad++;
                    $display("FAIL first_lit_digit0 got an=%b want an=1110", seg_an);
                end
            end
        end
    endtask

    task automatic test_hex_frames();
        int fd_cnt = 0;
        step(1'b0, 1'b1, 16'h12AF, 4'b0100);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0);
            fd_cnt += int'(frame_done);
            total++;
            if ({seg_an, seg_cat, seg_dp, frame_done} !== {e_an, e_cat, e_dp, e_fd}) begin
                bad++;
                $display("FAIL hex_12AF t=%0d got an=%b cat=%b dp=%b fd=%b want an=%b cat=%b dp=%b fd=%b",
                         m_t, seg_an, seg_cat, seg_dp, frame_done, e_an, e_cat, e_dp, e_fd);
            end
            if (seg_an == 4'b1110 && m_dd == 16'h12AF) begin
                total++;
                if (seg_cat !== 7'b0001110) begin
                    bad++;
                    $display("FAIL digit0_F got cat=%b want cat=0001110", seg_cat);
                end
            end
        end
        total++;
        if (fd_cnt != 2) begin
            bad++;
            $display("FAIL frame_done_count got %0d want 2", fd_cnt);
        end
    endtask

    // Idle (checked) until the model phase within the frame equals ph.
    task automatic run_to(input int ph);
        for (int i = 0; i < FRAME && (m_t % FRAME) != ph; i++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0);
            total++;
            if ({seg_an, seg_cat, seg_dp, frame_done} !== {e_an, e_cat, e_dp, e_fd}) begin
                bad++;
                $display("FAIL run_to t=%0d got an=%b cat=%b dp=%b fd=%b want an=%b cat=%b dp=%b fd=%b",
                         m_t, seg_an, seg_cat, seg_dp, frame_done, e_an, e_cat, e_dp, e_fd);
            end
        end
    endtask

    task automatic test_midframe();
        run_to(1 * CDIV + 1);
        step(1'b0, 1'b1, 16'h1111, 4'h0);
        run_to(2 * CDIV + 2);
        step(1'b0, 1'b1, 16'h2222, 4'h0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0);
            total++;
            if ({seg_an, seg_cat, seg_dp, frame_done} !== {e_an, e_cat, e_dp, e_fd}) begin
                bad++;
                $display("FAIL midframe t=%0d got an=%b cat=%b dp=%b fd=%b want an=%b cat=%b dp=%b fd=%b",
                         m_t, seg_an, seg_cat, seg_dp, frame_done, e_an, e_cat, e_dp, e_fd);
            end
        end
    endtask

    task automatic test_coincident();
        run_to(FRAME - 1);
        step(1'b0, 1'b1, 16'h5A3C, 4'b1001);
        for (int i = 0; i < FRAME + 4; i++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0);
            total++;
            if ({seg_an, seg_cat, seg_dp, frame_done} !== {e_an, e_cat, e_dp, e_fd}) begin
                bad++;
                $display("FAIL coincident t=%0d got an=%b cat=%b dp=%b fd=%b want an=%b cat=%b dp=%b fd=%b",
                         m_t, seg_an, seg_cat, seg_dp, frame_done, e_an, e_cat, e_dp, e_fd);
            end
            if (i == 1) begin
                total++;
                if ({seg_an, seg_cat, seg_dp} !== {4'b1110, ~seg_tab[4'hC], 1'b0}) begin
                    bad++;
                    $display("FAIL coincident_immediate got an=%b cat=%b dp=%b want an=1110 cat=%b dp=0",
                             seg_an, seg_cat, seg_dp, ~seg_tab[4'hC]);
                end
            end
        end
    endtask

    task automatic test_lzb();
        logic [15:0] vals [2] = '{16'h0040, 16'h0000};
        for (int v = 0; v < 2; v++) begin
            run_to(3);
            step(1'b0, 1'b1, vals[v], 4'h0);
            for (int i = 0; i < 2 * FRAME; i++) begin
                step(1'b0, 1'b0, 16'h0, 4'h0);
                total++;
                if ({seg_an, seg_cat, seg_dp, frame_done} !== {e_an, e_cat, e_dp, e_fd}) begin
                    bad++;
                    $display("FAIL lzb v=%h t=%0d got an=%b cat=%b dp=%b want an=%b cat=%b dp=%b",
                             vals[v], m_t, seg_an, seg_cat, seg_dp, e_an, e_cat, e_dp);
                end
            end
        end
    endtask

    task automatic test_random();
        logic ld;
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom_range(0, 7) == 0);
            step(1'b0, ld, 16'($urandom), 4'($urandom));
            total++;
            if ({seg_an, seg_cat, seg_dp, frame_done} !== {e_an, e_cat, e_dp, e_fd}) begin
                bad++;
                $display("FAIL random t=%0d got an=%b cat=%b dp=%b fd=%b want an=%b cat=%b dp=%b fd=%b",
                         m_t, seg_an, seg_cat, seg_dp, frame_done, e_an, e_cat, e_dp, e_fd);
            end
        end
    endtask

    task automatic test_reset_mid();
        run_to(2 * CDIV + 2);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        total++;
        if ({seg_an, seg_cat, seg_dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_off got an=%b cat=%b dp=%b fd=%b want an=1111 cat=1111111 dp=1 fd=0",
                     seg_an, seg_cat, seg_dp, frame_done);
        end
        for (int i = 0; i < FRAME + 2; i++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0);
            total++;
            if ({seg_an, seg_cat, seg_dp, frame_done} !== {e_an, e_cat, e_dp, e_fd}) begin
                bad++;
                $display("FAIL reset_mid t=%0d got an=%b cat=%b dp=%b fd=%b want an=%b cat=%b dp=%b fd=%b",
                         m_t, seg_an, seg_cat, seg_dp, frame_done, e_an, e_cat, e_dp, e_fd);
            end
            if (i == 1) begin
                total++;
                if ({seg_an, seg_cat} !== {4'b1110, 7'b1000000}) begin
                    bad++;
                    $display("FAIL reset_mid_restart got an=%b cat=%b want an=1110 cat=1000000",
                             seg_an, seg_cat);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_hex_frames();
        test_midframe();
        test_coincident();
        test_lzb();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
